// File: rtl/sine_pkg.sv
// sine_pkg: shared types and elaboration-time quarter-wave
// ROM contents for the sine_dds_gen waveform source.
package sine_pkg;

    typedef enum logic [1:0] {
        WM_FULL   = 2'd0,
        WM_HALF   = 2'd1,
        WM_ABS    = 2'd2,
        WM_SQUARE = 2'd3
    } wave_mode_t;

    // Q2.30 fixed-point constants for the table generator
    localparam longint FX_ONE     = 64'sd1073741824;
    localparam longint HALF_PI_FX = 64'sd1686629713;

    // round((2**(out_w-1)-1) * sin(pi/2*(i+0.5)/2**addr_w))
    // Integer Taylor series so the table folds to constants.
    function automatic int quarter_rom_entry(
        input int i,
        input int out_w,
        input int addr_w
    );
        longint x;
        longint term;
        longint sum;
        longint den;
        longint amp;
        x    = HALF_PI_FX * (64'sd2 * longint'(i) + 64'sd1);
        x    = x / (64'sd2 <<< addr_w);
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            den  = longint'(2 * k) * longint'(2 * k + 1);
            term = ((term * x) / FX_ONE) * x / FX_ONE;
            term = -term / den;
            sum  = sum + term;
        end
        amp = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        return int'((amp * sum + FX_ONE / 64'sd2) / FX_ONE);
    endfunction

endpackage

// File: rtl/sine_dds_gen_if.sv
// sine_dds_gen_if: valid/ready sample stream from the DDS
// towards PWM/DAC drivers.
interface sine_dds_gen_if #(
    parameter int OUT_W = 8
);

    logic [OUT_W-1:0] sample;
    logic             sample_sof;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample,
        output sample_sof,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_sof,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: quarter-wave sine magnitude table with a
// registered read port; contents built at elaboration time.
module sine_quarter_rom
    import sine_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [OUT_W-2:0]  o_data
);

    localparam int N = 2 ** ADDR_W;

    logic [OUT_W-2:0] w_tab [N];
    logic [OUT_W-2:0] r_data;

    for (genvar g = 0; g < N; g++) begin : g_tab
        localparam int V = quarter_rom_entry(g, OUT_W, ADDR_W);
        assign w_tab[g] = V[OUT_W-2:0];
    end

    // registered read; holds its word while the pipe is stalled
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data <= w_tab[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/sine_dds_gen.sv
// sine_dds_gen: phase-accumulator DDS with quarter-wave ROM,
// four waveform modes and a valid/ready sample output.
module sine_dds_gen
    import sine_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int ADDR_W  = 5,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_off,
    input  wave_mode_t         mode,
    input  logic               phase_clr,
    sine_dds_gen_if.master     smp
);

    // PHASE_W must be at least ADDR_W+2
    localparam int PW = ADDR_W + 2;

    // shadow configuration
    logic [PHASE_W-1:0] r_freq_sh;
    logic [PHASE_W-1:0] r_off_sh;
    wave_mode_t         r_mode_sh;

    // accumulator and pending start-of-period tag
    logic [PHASE_W-1:0] r_acc;
    logic               r_sof_pend;

    // stage 1: phase bits for the ROM
    logic               r_s1_valid;
    logic [PW-1:0]      r_s1_ph;
    wave_mode_t         r_s1_mode;
    logic               r_s1_sof;

    // stage 2: alongside the ROM read data
    logic               r_s2_valid;
    logic [1:0]         r_s2_quad;
    wave_mode_t         r_s2_mode;
    logic               r_s2_sof;

    // output register
    logic [OUT_W-1:0]   r_sample;
    logic               r_sof;
    logic               r_valid;

    logic               w_adv;
    logic               w_issue;
    logic               w_sof;
    logic [PHASE_W-1:0] w_acc_base;
    logic [PHASE_W-1:0] w_acc_nxt;
    logic               w_carry;
    logic [PHASE_W-1:0] w_ph;
    logic               w_ph_unused;
    logic [1:0]         w_quad;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [OUT_W-2:0]   w_q;
    logic               w_upper;
    logic [OUT_W-1:0]   w_dec;

    // whole pipe advances only when the output slot frees up
    assign w_adv   = !r_valid || smp.sample_ready;
    assign w_issue = en && w_adv;

    // a clear this cycle replaces the accumulator before use
    assign w_acc_base = phase_clr ? '0 : r_acc;
    assign w_sof      = phase_clr || r_sof_pend;

    assign {w_carry, w_acc_nxt} =
        {1'b0, w_acc_base} + {1'b0, r_freq_sh};

    // only the top PW phase bits address the table
    assign w_ph        = w_acc_base + r_off_sh;
    assign w_ph_unused = ^w_ph;

    // odd quadrants read the quarter table mirrored
    assign w_quad = r_s1_ph[PW-1 -: 2];
    assign w_idx  = r_s1_ph[ADDR_W-1:0];
    assign w_addr = w_idx ^ {ADDR_W{w_quad[0]}};

    sine_quarter_rom #(
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk    (clk),
        .i_en   (w_adv),
        .i_addr (w_addr),
        .o_data (w_q)
    );

    // shadow config registers, loaded on cfg_load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_freq_sh <= '0;
            r_off_sh  <= '0;
            r_mode_sh <= WM_FULL;
        end else if (cfg_load) begin
            r_freq_sh <= freq_word;
            r_off_sh  <= phase_off;
            r_mode_sh <= mode;
        end
    end

    // phase accumulator; carry-out tags the next sample as sof
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_sof_pend <= 1'b1;
        end else if (w_issue) begin
            r_acc      <= w_acc_nxt;
            r_sof_pend <= w_carry;
        end else if (phase_clr) begin
            r_acc      <= '0;
            r_sof_pend <= 1'b1;
        end
    end

    // stage 1: capture issued phase, mode and tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ph    <= '0;
            r_s1_mode  <= WM_FULL;
            r_s1_sof   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= w_issue;
            r_s1_ph    <= w_ph[PHASE_W-1 -: PW];
            r_s1_mode  <= r_mode_sh;
            r_s1_sof   <= w_sof;
        end
    end

    // stage 2: carry quadrant and mode beside the ROM read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_quad  <= '0;
            r_s2_mode  <= WM_FULL;
            r_s2_sof   <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_quad  <= w_quad;
            r_s2_mode  <= r_s1_mode;
            r_s2_sof   <= r_s1_sof;
        end
    end

    // shape the quarter magnitude into the selected waveform
    always_comb begin
        w_upper = !r_s2_quad[1];
        w_dec   = '0;
        unique case (r_s2_mode)
            WM_FULL: begin
                w_dec = w_upper ? {1'b1, w_q} : {1'b0, ~w_q};
            end
            WM_HALF: begin
                w_dec = w_upper ? {w_q, 1'b1} : '0;
            end
            WM_ABS: begin
                w_dec = {w_q, 1'b1};
            end
            WM_SQUARE: begin
                w_dec = w_upper ? '1 : '0;
            end
        endcase
    end

    // output register; holds while valid and not ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_sof    <= 1'b0;
        end else if (w_adv) begin
            r_valid  <= r_s2_valid;
            r_sample <= w_dec;
            r_sof    <= r_s2_sof;
        end
    end

    assign smp.sample       = r_sample;
    assign smp.sample_sof   = r_sof;
    assign smp.sample_valid = r_valid;

endmodule
